// File: rtl/sa2_pkg.sv
// Shared widths and state encoding for the
// 2x2 systolic-array operand loader.
package sa2_pkg;

  localparam int DW     = 8;
  localparam int N_FILT = 9;
  localparam int N_DATA = 16;
  localparam int N_REG  = N_FILT + N_DATA;
  localparam int AW     = 5;

  typedef enum logic [1:0] {
    LOAD_FILT = 2'd0,
    LOAD_DATA = 2'd1,
    RUN       = 2'd2
  } state_e;

endpackage

// File: rtl/sa2_operand_regfile.sv
// Flat operand store: filter at 0..N_FILT-1,
// data tile above it, one write port.
module sa2_operand_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 25,
  parameter int AW   = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [AW-1:0]             addr_i,
  input  logic [DW-1:0]             wdata_i,
  output logic [NREG-1:0][DW-1:0]   regs_o
);

  logic [NREG-1:0][DW-1:0] regs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '0;
    end else if (we_i && (int'(addr_i) < NREG)) begin
      regs_q[addr_i] <= wdata_i;
    end
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/sa2_operand_loader.sv
// Byte-stream unpacker feeding the 2x2 conv array:
// filter + 4x4 tile load, then hold until done_sa2.
module sa2_operand_loader #(
  parameter int DW     = sa2_pkg::DW,
  parameter int N_FILT = sa2_pkg::N_FILT,
  parameter int N_DATA = sa2_pkg::N_DATA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          keep_filter,
  output logic [DW-1:0] a11, a12, a13, a14,
  output logic [DW-1:0] a21, a22, a23, a24,
  output logic [DW-1:0] a31, a32, a33, a34,
  output logic [DW-1:0] a41, a42, a43, a44,
  output logic [DW-1:0] b11, b12, b13,
  output logic [DW-1:0] b21, b22, b23,
  output logic [DW-1:0] b31, b32, b33,
  output logic          active_sa2,
  input  logic          done_sa2,
  output logic          frame_done,
  output logic          filt_loaded
);

  import sa2_pkg::*;

  localparam int NR = N_FILT + N_DATA;

  state_e          state_q;
  logic [AW-1:0]   idx_q;
  logic            active_q;
  logic            fdone_q;
  logic            floaded_q;
  logic            accept;
  logic [AW-1:0]   waddr;
  logic [NR-1:0][DW-1:0] regs;

  assign in_ready = (state_q != RUN);
  assign accept   = in_valid & in_ready;
  assign waddr    = (state_q == LOAD_DATA) ?
                    idx_q + AW'(N_FILT) : idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD_FILT;
      idx_q     <= '0;
      active_q  <= 1'b0;
      fdone_q   <= 1'b0;
      floaded_q <= 1'b0;
    end else begin
      fdone_q <= 1'b0;
      unique case (state_q)
        LOAD_FILT: if (accept) begin
          if (idx_q == AW'(N_FILT - 1)) begin
            state_q   <= LOAD_DATA;
            idx_q     <= '0;
            floaded_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        LOAD_DATA: if (accept) begin
          if (idx_q == AW'(N_DATA - 1)) begin
            state_q  <= RUN;
            idx_q    <= '0;
            active_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        RUN: if (done_sa2) begin
          // keep_filter only matters if a filter was ever loaded
          state_q  <= (keep_filter && floaded_q) ?
                      LOAD_DATA : LOAD_FILT;
          active_q <= 1'b0;
          fdone_q  <= 1'b1;
        end
        default: begin
          state_q  <= LOAD_FILT;
          idx_q    <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  sa2_operand_regfile #(
    .DW   (DW),
    .NREG (NR),
    .AW   (AW)
  ) u_regfile (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (accept),
    .addr_i  (waddr),
    .wdata_i (in_data),
    .regs_o  (regs)
  );

  assign active_sa2  = active_q;
  assign frame_done  = fdone_q;
  assign filt_loaded = floaded_q;

  assign b11 = regs[0];
  assign b12 = regs[1];
  assign b13 = regs[2];
  assign b21 = regs[3];
  assign b22 = regs[4];
  assign b23 = regs[5];
  assign b31 = regs[6];
  assign b32 = regs[7];
  assign b33 = regs[8];

  assign a11 = regs[N_FILT + 0];
  assign a12 = regs[N_FILT + 1];
  assign a13 = regs[N_FILT + 2];
  assign a14 = regs[N_FILT + 3];
  assign a21 = regs[N_FILT + 4];
  assign a22 = regs[N_FILT + 5];
  assign a23 = regs[N_FILT + 6];
  assign a24 = regs[N_FILT + 7];
  assign a31 = regs[N_FILT + 8];
  assign a32 = regs[N_FILT + 9];
  assign a33 = regs[N_FILT + 10];
  assign a34 = regs[N_FILT + 11];
  assign a41 = regs[N_FILT + 12];
  assign a42 = regs[N_FILT + 13];
  assign a43 = regs[N_FILT + 14];
  assign a44 = regs[N_FILT + 15];

endmodule

// File: tb/tb_sa2_operand_loader.sv
// Randomized bench for sa2_operand_loader against a
// frame-level model of filter/tile contents.
module tb_sa2_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       keep_filter;
  logic       done_sa2;
  logic       active_sa2;
  logic       frame_done;
  logic       filt_loaded;
  logic [7:0] a11, a12, a13, a14, a21, a22, a23, a24;
  logic [7:0] a31, a32, a33, a34, a41, a42, a43, a44;
  logic [7:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;

  always #5 clk = ~clk;

  sa2_operand_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .keep_filter(keep_filter),
    .a11(a11), .a12(a12), .a13(a13), .a14(a14),
    .a21(a21), .a22(a22), .a23(a23), .a24(a24),
    .a31(a31), .a32(a32), .a33(a33), .a34(a34),
    .a41(a41), .a42(a42), .a43(a43), .a44(a44),
    .b11(b11), .b12(b12), .b13(b13),
    .b21(b21), .b22(b22), .b23(b23),
    .b31(b31), .b32(b32), .b33(b33),
    .active_sa2(active_sa2), .done_sa2(done_sa2),
    .frame_done(frame_done), .filt_loaded(filt_loaded)
  );

  logic [8:0][7:0]  got_b;
  logic [15:0][7:0] got_a;
  assign got_b = {b33, b32, b31, b23, b22, b21,
                  b13, b12, b11};
  assign got_a = {a44, a43, a42, a41, a34, a33, a32, a31,
                  a24, a23, a22, a21, a14, a13, a12, a11};

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_b [9];
  logic [7:0] exp_a [16];
  bit         m_floaded;
  bit         m_full;
  logic [7:0] stream [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int frame_len();
    return m_full ? 25 : 16;
  endfunction

  task automatic model_reset();
    foreach (exp_b[i]) exp_b[i] = '0;
    foreach (exp_a[i]) exp_a[i] = '0;
    m_floaded = 1'b0;
    m_full    = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s_b%0d", tag, i), got_b[i], exp_b[i]);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_a%0d", tag, i), got_a[i], exp_a[i]);
  endtask

  task automatic fill_stream(input int n, input int base);
    stream.delete();
    for (int i = 0; i < n; i++)
      stream.push_back(base < 0 ? 8'($urandom) : 8'(base + i));
  endtask

  // Push nbytes of stream into the current frame.
  task automatic push(input int nbytes, input bit gaps);
    int  total = frame_len();
    bit  full  = m_full;
    for (int i = 0; i < nbytes; i++) begin
      int tries = 0;
      bit took  = 0;
      int slot;
      logic [7:0] v = stream[i];
      while (!took) begin
        @(negedge clk);
        done_sa2 = ($urandom_range(0, 3) == 0);
        tries++;
        if (gaps && tries < 8 && $urandom_range(0, 1) == 1) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
        end else begin
          in_valid = 1'b1;
          in_data  = v;
          took     = 1;
        end
        chk("rdy_load", in_ready, 1);
        chk("act_load", active_sa2, 0);
      end
      @(posedge clk);
      #1;
      if (full && i < 9) begin
        exp_b[i] = v;
        if (i == 8) m_floaded = 1'b1;
        chk($sformatf("lat_b%0d", i), got_b[i], v);
      end else begin
        slot = i - (full ? 9 : 0);
        exp_a[slot] = v;
        chk($sformatf("lat_a%0d", slot), got_a[slot], v);
      end
    end
    if (nbytes == total) begin
      @(negedge clk);
      in_valid = 1'b0;
      done_sa2 = 1'b0;
      chk("act_run0", active_sa2, 1);
      chk("rdy_run0", in_ready, 0);
      chk("fl_run0", filt_loaded, m_floaded);
      chk("fd_run0", frame_done, 0);
      check_regs("frame");
    end
  endtask

  // Hold in RUN for pre cycles, then assert done for hold cycles.
  task automatic do_done(input int pre, input int hold,
                         input bit keep);
    repeat (pre) begin
      @(negedge clk);
      chk("act_run", active_sa2, 1);
      chk("rdy_run", in_ready, 0);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      keep_filter = $urandom_range(0, 1);
    end
    if (pre > 0) begin
      @(negedge clk);
      check_regs("frozen");
    end
    in_valid    = 1'b0;
    done_sa2    = 1'b1;
    keep_filter = keep;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) keep_filter = ~keep;
      chk("fd_pulse", frame_done, (i == 0) ? 1 : 0);
      chk("act_done", active_sa2, 0);
      chk("rdy_done", in_ready, 1);
    end
    done_sa2    = 1'b0;
    keep_filter = $urandom_range(0, 1);
    @(negedge clk);
    chk("fd_after", frame_done, 0);
    m_full = !(keep && m_floaded);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    keep_filter = 1'b0;
    done_sa2 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rdy", in_ready, 1);
    chk("rst_act", active_sa2, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_fl", filt_loaded, 0);
    check_regs("rst");
    rst = 1'b1;

    fill_stream(25, 1);
    push(frame_len(), 0);
    chk("b11_is1", b11, 8'd1);
    chk("a44_is25", a44, 8'd25);
    do_done(2, 3, 0);

    fill_stream(25, -1);
    push(frame_len(), 1);
    do_done(1, 2, 1);

    chk("kept_len", frame_len(), 16);
    fill_stream(16, 8'h80);
    push(frame_len(), 0);
    chk("a11_80", a11, 8'h80);
    chk("a44_8f", a44, 8'h8f);
    do_done(0, 1, 0);

    for (int f = 0; f < 8; f++) begin
      fill_stream(25, -1);
      push(frame_len(), 1);
      do_done($urandom_range(0, 3), $urandom_range(1, 3),
              $urandom_range(0, 1));
    end

    fill_stream(25, -1);
    push(frame_len(), 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rstrun_act", active_sa2, 0);
    chk("rstrun_fl", filt_loaded, 0);
    chk("rstrun_rdy", in_ready, 1);
    check_regs("rstrun");
    @(negedge clk);
    rst = 1'b1;

    fill_stream(25, -1);
    push(12, 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rstmid_fl", filt_loaded, 0);
    chk("rstmid_act", active_sa2, 0);
    chk("rstmid_fd", frame_done, 0);
    check_regs("rstmid");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;

    keep_filter = 1'b1;
    fill_stream(25, -1);
    push(frame_len(), 1);
    chk("post_rst_b11", b11, stream[0]);
    do_done(1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sa2_operand_loader.md
# sa2_operand_loader

Upstream feeder for the 2x2 convolution systolic array. It accepts a byte stream over a valid/ready handshake and unpacks it into the 3x3 filter registers (b11..b33) and the 4x4 input-tile registers (a11..a44). When a frame is complete it raises `active_sa2`, holds every operand stable until the array returns `done_sa2`, then reopens the stream for the next frame. The filter can optionally be kept from the previous frame so that only the 16 data bytes are streamed.

## Interface
- `DW`, default 8: operand byte width.
- `N_FILT`, default 9: filter bytes per frame, row-major b11,b12,b13,b21..b33.
- `N_DATA`, default 16: data bytes per frame, row-major a11,a12..a44.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset. 0 resets the block.
- `in_valid` in 1: a stream byte is present.
- `in_ready` out 1: the loader can accept a byte.
- `in_data` in DW: stream byte.
- `keep_filter` in 1: level input; when 1, the next frame skips the filter bytes.
- `a11`..`a44` out DW each (16 ports): data tile, registered.
- `b11`..`b33` out DW each (9 ports): filter, registered.
- `active_sa2` out 1: start/run level to the array.
- `done_sa2` in 1: completion from the array.
- `frame_done` out 1: one-cycle pulse when a frame's computation finishes.
- `filt_loaded` out 1: the filter registers hold a valid filter.

## Operation
- States: `LOAD_FILT`, `LOAD_DATA`, `RUN`.
- A byte is accepted on a rising edge where `in_valid & in_ready`.
- `in_ready` is 1 in `LOAD_FILT` and `LOAD_DATA`, and 0 in `RUN`.
- Write index `idx` is 5 bits.
  - `LOAD_FILT`: the byte goes to filter slot `idx` (0..8).
  - `LOAD_DATA`: the byte goes to data slot `idx` (0..15).
  - `idx` increments only on an accepted byte.
- `LOAD_FILT` transitions:
  - When the 9th byte is accepted, go to `LOAD_DATA`, set `idx` to 0 and set `filt_loaded` to 1.
- `LOAD_DATA` transitions:
  - When the 16th byte is accepted, go to `RUN` and set `idx` to 0.
- `RUN`:
  - `active_sa2` is 1 for the whole state.
  - All a/b outputs are frozen.
  - When `done_sa2` is 1 at a clock edge, leave `RUN`:
    - If `keep_filter & filt_loaded`, the next state is `LOAD_DATA`.
    - Otherwise the next state is `LOAD_FILT`.
  - `frame_done` pulses for exactly that one following cycle.
- Outside `RUN`:
  - `done_sa2` is ignored.
  - `keep_filter` is sampled only on the `RUN` exit edge.
- Data registers are not cleared between frames; they are only overwritten.
- A filter reload overwrites all 9 filter slots.
- `filt_loaded` stays 1 until reset.
- No arithmetic is performed; bytes pass through unchanged at DW bits.

## Timing
- Reset values:
  - state = `LOAD_FILT`, `idx` = 0.
  - All a/b outputs = 0.
  - `active_sa2`, `frame_done` and `filt_loaded` = 0.
  - `in_ready` = 1 (combinational from state).
- Reset mid-frame or mid-`RUN` drops `active_sa2` immediately (asynchronous) and discards the partial frame.
- Load latency: a byte accepted at edge k is visible on its a/b output after edge k.
- `active_sa2` rises on the edge that accepts the 25th byte of a full frame, or the 16th byte of a kept-filter frame.
  - It is visible in the following cycle.
  - It is not asserted in the cycle where `in_ready` was last 1.
- Done handling:
  - With `done_sa2` sampled 1 at edge d: `active_sa2` = 0, `frame_done` = 1 and `in_ready` = 1 after edge d.
  - A new byte can be accepted at edge d+1.
- Minimum frame period is 25 + run cycles + 1 (full frame) or 16 + run cycles + 1 (kept filter).
- `in_valid` may drop at any time. Gaps stall `idx` without any loss of data.
- `done_sa2` held high for several cycles produces only one `frame_done` pulse. After exit, the block is in a load state and ignores `done_sa2`.
- If `done_sa2` is already 1 on the first `RUN` cycle, `RUN` lasts exactly 1 cycle.

## Structure
- Shared package `sa2_pkg` holds:
  - `DW`, `N_FILT`, `N_DATA`.
  - State encoding `LOAD_FILT`=0, `LOAD_DATA`=1, `RUN`=2.
- The top module contains the FSM, `idx` and handshake logic.
- One sub-module, `sa2_operand_regfile`, holds 25 DW registers.
  - Interface: write enable, 5-bit flat address (filter 0..8, data 9..24), write data.
  - Outputs: the 25 registers as flat outputs.
  - It has the same asynchronous active-low reset.

## Test plan
- Reset then a full frame (filter bytes 1..9, data bytes 10..25, `in_valid` always 1):
  - Expect b11=1, b33=9, a11=10, a44=25.
  - Expect `active_sa2`=1 from the cycle after the 25th accept, and `in_ready`=0.
- While in `RUN`, drive `done_sa2`=1 for 3 cycles:
  - Expect a single `frame_done` pulse, `active_sa2`=0 and `in_ready`=1.
  - Expect state `LOAD_FILT` (with `keep_filter`=0).
- `keep_filter`=1 at the `RUN` exit, then send data bytes 0x80..0x8F:
  - Expect the b registers unchanged and a11=0x80, a44=0x8F.
  - Expect `active_sa2` after only 16 accepts.
- Random `in_valid` gaps (50%) over a full frame:
  - Expect every register to equal the byte in stream order.
  - Expect no byte lost or duplicated.
- Assert `rst`=0 after 12 bytes:
  - Expect all outputs 0 and `filt_loaded`=0 immediately.
  - After release, expect the next frame to start at the filter.
- `keep_filter`=1 straight out of reset, then complete a frame:
  - Expect the first frame to load the filter anyway (`filt_loaded` was 0).
